// File: rtl/muldiv_seq.sv
// Sequential multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with a fixed latency of WIDTH+2 edges from start to result.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] dout,
  output logic             drdy,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_neg;
  logic             r_rneg;
  logic             r_bzero;
  logic             r_first;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_drdy;
  logic             r_busy;

  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_result;

  // MUL only needs the low half, which is sign-agnostic, so it runs unsigned.
  assign w_a_signed = (r_op == 3'b001) || (r_op == 3'b010) ||
                      (r_op == 3'b100) || (r_op == 3'b110);
  assign w_b_signed = (r_op == 3'b001) || (r_op == 3'b100) || (r_op == 3'b110);
  assign w_a_neg    = w_a_signed & r_a[WIDTH-1];
  assign w_b_neg    = w_b_signed & r_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -r_a : r_a;
  assign w_b_mag    = w_b_neg ? -r_b : r_b;

  assign w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_m};

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;
  // A zero divisor bypasses the sign fix-up; the most-negative / -1 case falls out naturally.
  assign w_quo = r_bzero ? {WIDTH{1'b1}} : (r_neg ? -r_lo : r_lo);
  assign w_rem = r_bzero ? r_a : (r_rneg ? -r_hi : r_hi);

  always_comb begin
    w_result = '0;
    case (r_op)
      3'b000:                 w_result = w_prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_result = w_prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_result = w_quo;
      default:                w_result = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dout  <= '0;
      r_drdy  <= 1'b0;
      r_busy  <= 1'b0;
      r_first <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_drdy <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= CALC;
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_first <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_busy <= 1'b1;
          if (r_first) begin
            // First CALC cycle loads magnitudes and sign flags before iterating.
            r_first <= 1'b0;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_rneg  <= w_a_neg;
            r_bzero <= (r_b == '0);
            r_hi    <= '0;
            r_lo    <= r_op[2] ? w_a_mag : w_b_mag;
            r_m     <= r_op[2] ? w_b_mag : w_a_mag;
          end else begin
            if (r_op[2]) begin
              r_hi <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
              r_lo <= {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
            end else begin
              {r_hi, r_lo} <= {w_add, r_lo[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) r_state <= FIX;
          end
        end
        FIX: begin
          r_dout  <= w_result;
          r_drdy  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dout = r_dout;
  assign drdy = r_drdy;
  assign busy = r_busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (WIDTH=32): directed corner cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_seq;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] dout;
  logic         drdy;
  logic         busy;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0]   D_OP  [11] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  localparam logic [W-1:0] D_A   [11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                          32'h7, 32'h7, 32'h80000000, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFB};
  localparam logic [W-1:0] D_B   [11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h2,
                                          32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
  localparam logic [W-1:0] D_EXP [11] = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                          32'hFFFFFFFF, 32'h00000007, 32'h80000000, 32'h00000000, 32'hFFFFFFFF,
                                          32'hFFFFFFFB};

  muldiv_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .dout  (dout),
    .drdy  (drdy),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint       sx;
    longint       sy;
    longint       ux;
    longint       uy;
    logic [63:0]  p;
    logic [W-1:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    r  = '0;
    case (o)
      3'd0: begin p = 64'(ux * uy); r = p[31:0];  end
      3'd1: begin p = 64'(sx * sy); r = p[63:32]; end
      3'd2: begin p = 64'(sx * uy); r = p[63:32]; end
      3'd3: begin p = 64'(ux * uy); r = p[63:32]; end
      3'd4: begin
        if (y == 0) r = '1;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x;
        else begin p = 64'(sx / sy); r = p[31:0]; end
      end
      3'd5: r = (y == 0) ? '1 : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = '0;
        else begin p = 64'(sx % sy); r = p[31:0]; end
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] pick_val();
    logic [W-1:0] v;
    case ($urandom_range(5, 0))
      0:       v = '0;
      1:       v = 32'h80000000;
      2:       v = 32'hFFFFFFFF;
      3:       v = 32'h1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Drives start across edge T, then scrambles the inputs to prove they were captured.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  // Counts edges after T until drdy; optionally pokes start during edges p0..p1.
  task automatic wait_rdy(input int p0, input int p1, output logic [W-1:0] res,
                          output int lat, output int busy_bad);
    res      = 'x;
    lat      = -1;
    busy_bad = 0;
    for (int k = 1; k <= LAT + 6; k++) begin
      @(posedge clk);
      #1;
      if (drdy === 1'b1) begin
        lat = k;
        res = dout;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      start = (k >= p0 && k <= p1);
      if (start) begin
        op = 3'($urandom);
        a  = $urandom;
        b  = $urandom;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] res;
    int           lat;
    int           bb;
    int           act;
    rst   = 1'b1;
    start = 1'b1;
    op    = 3'd0;
    a     = 32'd6;
    b     = 32'd6;
    repeat (2) @(posedge clk);
    #1;
    total++; if (dout !== '0)   begin bad++; $display("FAIL reset_dout got=%h exp=0", dout); end
    total++; if (drdy !== 1'b0) begin bad++; $display("FAIL reset_drdy got=%b exp=0", drdy); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst   = 1'b0;
    start = 1'b0;
    act   = 0;
    for (int k = 0; k < LAT + 6; k++) begin
      @(posedge clk);
      #1;
      if (drdy !== 1'b0 || busy !== 1'b0) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL reset_over_start active_cycles got=%0d exp=0", act); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(3'd0, 32'd6, 32'd6);
    wait_rdy(1000, 0, res, lat, bb);
    $display("txn reset_then_mul dout=%h lat=%0d", res, lat);
    total++; if (res !== 32'h24) begin bad++; $display("FAIL post_reset_mul got=%h exp=%h", res, 32'h24); end
    total++; if (lat !== LAT)    begin bad++; $display("FAIL post_reset_lat got=%0d exp=%0d", lat, LAT); end
  endtask

  task automatic test_latency();
    logic [W-1:0] res;
    int           lat;
    int           bb;
    issue(3'd0, 32'd6, 32'd6);
    wait_rdy(1000, 0, res, lat, bb);
    $display("txn mul 6x6 dout=%h lat=%0d", res, lat);
    total++; if (res !== 32'h24) begin bad++; $display("FAIL mul6x6 got=%h exp=%h", res, 32'h24); end
    total++; if (lat !== LAT)    begin bad++; $display("FAIL mul6x6_lat got=%0d exp=%0d", lat, LAT); end
    total++; if (bb !== 0)       begin bad++; $display("FAIL mul6x6_busy bad_cycles got=%0d exp=0", bb); end
    @(posedge clk);
    #1;
    total++; if (drdy !== 1'b0)   begin bad++; $display("FAIL drdy_pulse got=%b exp=0", drdy); end
    total++; if (dout !== 32'h24) begin bad++; $display("FAIL dout_hold got=%h exp=%h", dout, 32'h24); end
  endtask

  task automatic test_directed();
    logic [W-1:0] res;
    int           lat;
    int           bb;
    for (int i = 0; i < 11; i++) begin
      issue(D_OP[i], D_A[i], D_B[i]);
      wait_rdy(1000, 0, res, lat, bb);
      $display("txn directed%0d op=%0d a=%h b=%h dout=%h lat=%0d", i, D_OP[i], D_A[i], D_B[i], res, lat);
      total++; if (res !== D_EXP[i]) begin bad++; $display("FAIL directed%0d got=%h exp=%h", i, res, D_EXP[i]); end
      total++; if (lat !== LAT)      begin bad++; $display("FAIL directed%0d_lat got=%0d exp=%0d", i, lat, LAT); end
    end
  endtask

  task automatic test_ignore_start();
    logic [W-1:0] res;
    int           lat;
    int           bb;
    int           act;
    issue(3'd0, 32'd6, 32'd6);
    wait_rdy(5, 7, res, lat, bb);
    $display("txn ignore_mid_calc dout=%h lat=%0d", res, lat);
    total++; if (res !== 32'h24) begin bad++; $display("FAIL ignore_calc got=%h exp=%h", res, 32'h24); end
    total++; if (lat !== LAT)    begin bad++; $display("FAIL ignore_calc_lat got=%0d exp=%0d", lat, LAT); end
    issue(3'd5, 32'd100, 32'd7);
    wait_rdy(LAT - 2, LAT - 1, res, lat, bb);
    $display("txn ignore_late dout=%h lat=%0d", res, lat);
    total++; if (res !== 32'd14) begin bad++; $display("FAIL ignore_late got=%h exp=%h", res, 32'd14); end
    total++; if (lat !== LAT)    begin bad++; $display("FAIL ignore_late_lat got=%0d exp=%0d", lat, LAT); end
    act = 0;
    for (int k = 0; k < LAT + 6; k++) begin
      @(posedge clk);
      #1;
      if (drdy !== 1'b0 || busy !== 1'b0) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL not_queued active_cycles got=%0d exp=0", act); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] old;
    int           lat;
    int           bb;
    int           held_bad;
    issue(3'd0, 32'd6, 32'd6);
    wait_rdy(1000, 0, old, lat, bb);
    x = $urandom;
    y = $urandom;
    issue(3'd3, x, y);
    lat      = -1;
    held_bad = 0;
    res      = 'x;
    for (int k = 1; k <= LAT + 6; k++) begin
      @(posedge clk);
      #1;
      if (drdy === 1'b1) begin
        lat = k;
        res = dout;
        break;
      end
      if (dout !== 32'h24) held_bad++;
    end
    $display("txn back_to_back mulhu a=%h b=%h dout=%h lat=%0d", x, y, res, lat);
    total++; if (res !== model(3'd3, x, y)) begin bad++; $display("FAIL b2b got=%h exp=%h", res, model(3'd3, x, y)); end
    total++; if (lat !== LAT)  begin bad++; $display("FAIL b2b_lat got=%0d exp=%0d", lat, LAT); end
    total++; if (held_bad !== 0) begin bad++; $display("FAIL b2b_hold bad_cycles got=%0d exp=0", held_bad); end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] res;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [2:0]   o;
    int           lat;
    int           bb;
    int           act;
    issue(3'd0, 32'd3, 32'd5);
    wait_rdy(1000, 0, res, lat, bb);
    total++; if (res !== 32'd15) begin bad++; $display("FAIL pre_reset_mul got=%h exp=%h", res, 32'd15); end
    issue(3'd0, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (dout !== '0)   begin bad++; $display("FAIL midrst_dout got=%h exp=0", dout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++; if (drdy !== 1'b0) begin bad++; $display("FAIL midrst_drdy got=%b exp=0", drdy); end
    act = 0;
    for (int k = 0; k < LAT + 6; k++) begin
      @(posedge clk);
      #1;
      if (drdy !== 1'b0) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL midrst_no_drdy pulses got=%0d exp=0", act); end
    o = 3'($urandom);
    x = pick_val();
    y = pick_val();
    issue(o, x, y);
    wait_rdy(1000, 0, res, lat, bb);
    $display("txn after_midrst op=%0d a=%h b=%h dout=%h lat=%0d", o, x, y, res, lat);
    total++; if (res !== model(o, x, y)) begin bad++; $display("FAIL after_midrst got=%h exp=%h", res, model(o, x, y)); end
    total++; if (lat !== LAT) begin bad++; $display("FAIL after_midrst_lat got=%0d exp=%0d", lat, LAT); end
  endtask

  task automatic test_random();
    logic [W-1:0] res;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] exp_v;
    logic [2:0]   o;
    int           lat;
    int           bb;
    for (int i = 0; i < 60; i++) begin
      o     = 3'($urandom);
      x     = pick_val();
      y     = pick_val();
      exp_v = model(o, x, y);
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
      issue(o, x, y);
      wait_rdy(1000, 0, res, lat, bb);
      $display("txn rand%0d op=%0d a=%h b=%h dout=%h exp=%h lat=%0d", i, o, x, y, res, exp_v, lat);
      total++; if (res !== exp_v) begin bad++; $display("FAIL rand%0d op=%0d got=%h exp=%h", i, o, res, exp_v); end
      total++; if (lat !== LAT)   begin bad++; $display("FAIL rand%0d_lat got=%0d exp=%0d", i, lat, LAT); end
      total++; if (bb !== 0)      begin bad++; $display("FAIL rand%0d_busy bad_cycles got=%0d exp=0", i, bb); end
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    test_reset();
    test_latency();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
